ulpi_reg_access: RTL and testbench
==================================

ULPI_REG_ACCESS -- requirements
Module: ulpi_reg_access

Interface
REQ-001 SHALL have parameter RETRY_LIMIT, default 4, meaning the number of PHY aborts tolerated per request before error completion (legal 1..15).
REQ-002 SHALL have port ulpi_clk, in, 1: 60 MHz ULPI clock; all logic is in this domain.
REQ-003 SHALL have port ulpi_rst, in, 1: asynchronous active-high reset.
REQ-004 SHALL have port ulpi_dir, in, 1: PHY bus ownership (1 = PHY drives).
REQ-005 SHALL have port ulpi_nxt, in, 1: PHY throttle/next.
REQ-006 SHALL have port ulpi_data_in, in, 8: bus value sampled from PHY.
REQ-007 SHALL have port ulpi_data_out, out, 8: link drive value; the pad drives it only while ulpi_dir=0.
REQ-008 SHALL have port ulpi_stp, out, 1: ULPI stop.
REQ-009 SHALL have ports req_valid in 1, req_ready out 1, req_write in 1, req_addr in 6, req_wdata in 8: register request, valid/ready handshake.
REQ-010 SHALL have ports resp_valid out 1, resp_rdata out 8, resp_err out 1: one-cycle completion pulse (no back-pressure).
REQ-011 SHALL have ports rx_cmd_valid out 1, rx_cmd out 8: one-cycle RX CMD pulse for the line-state/event tracker.

Function
REQ-012 SHALL register all outputs; dir_q is ulpi_dir delayed one cycle; turnaround cycle = ulpi_dir != dir_q.
REQ-013 SHALL implement states IDLE, TXCMD, WDATA, STP, RD_TURN, RD_DATA, WAIT_DIR, TURN.
REQ-014 req_ready SHALL be 1 only in IDLE with ulpi_dir=0 and dir_q=0; the request is latched on req_valid&req_ready, entering TXCMD next cycle.
REQ-015 In IDLE/TURN/WAIT_DIR ulpi_data_out SHALL be 8'h00 (NOOP) and ulpi_stp 0.
REQ-016 TXCMD SHALL drive {2'b10,addr} for write or {2'b11,addr} for read, held until ulpi_nxt=1 with ulpi_dir=0.
REQ-017 Write: TXCMD+nxt -> WDATA driving wdata; WDATA+nxt -> STP driving 8'h00 with ulpi_stp=1 for exactly one cycle -> IDLE; resp_valid=1, resp_err=0, resp_rdata=0 in the STP cycle.
REQ-018 Read: TXCMD+nxt -> RD_TURN (data_out 8'h00); RD_TURN with dir=1,nxt=0 -> RD_DATA; RD_DATA captures ulpi_data_in to resp_rdata with resp_valid=1 next cycle -> WAIT_DIR.
REQ-019 RD_TURN with ulpi_dir=0 SHALL complete with resp_valid=1, resp_err=1, resp_rdata=0 and return to IDLE.
REQ-020 Abort: ulpi_dir=1 in TXCMD or WDATA, or dir=1&nxt=1 in RD_TURN, SHALL increment the abort counter and go to WAIT_DIR with the request retained; ulpi_stp stays 0.
REQ-021 WAIT_DIR SHALL hold until ulpi_dir=0, then TURN for one cycle, then TXCMD (retry) if a request is pending, else IDLE.
REQ-022 When the abort counter reaches RETRY_LIMIT the request SHALL complete with resp_valid=1, resp_err=1 on the TURN exit instead of retrying; the counter clears on each accept.
REQ-023 rx_cmd_valid SHALL pulse with rx_cmd=ulpi_data_in for each cycle with ulpi_dir=1, dir_q=1, ulpi_nxt=0, state not RD_DATA; nxt=1 cycles (packet data) are ignored.
REQ-024 Exactly one resp_valid SHALL occur per accepted request.

Reset
REQ-025 ulpi_rst SHALL asynchronously force IDLE, ulpi_data_out=8'h00, ulpi_stp=0, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, rx_cmd_valid=0, rx_cmd=0, abort counter 0, dir_q=0; a request in flight is dropped without response.
REQ-026 After release req_ready SHALL assert no earlier than the first clock with dir=0 and dir_q=0.

Verification
REQ-027 Write addr 6'h0A data 8'h55, nxt=1 one cycle after each drive -> bus 8'h8A, 8'h55, 8'h00+stp=1 one cycle; resp_valid=1, resp_err=0.
REQ-028 Read addr 6'h00, PHY: nxt, dir turnaround, data 8'h24, dir low -> resp_rdata=8'h24, resp_err=0, req_ready returns after TURN.
REQ-029 PHY asserts dir during write TXCMD, drives RX CMD 8'h4D, drops dir -> rx_cmd_valid with 8'h4D, TXCMD 8'h8A reissued after one TURN cycle, single resp_valid.
REQ-030 RETRY_LIMIT=2, abort every attempt -> second abort completes with resp_err=1, no third TXCMD.
REQ-031 Read with dir never asserted in RD_TURN -> resp_err=1, resp_rdata=0; ulpi_rst mid-WDATA -> all outputs at reset values immediately, no resp_valid.

Source files
------------

// File: rtl/ulpi_reg_access.sv
// ULPI link-side register access engine: issues register read/write TX CMDs,
// survives PHY aborts with bounded retries and forwards RX CMD bytes.
`timescale 1ns/1ps
module ulpi_reg_access #(
  parameter int unsigned RETRY_LIMIT = 4
) (
  input  logic       ulpi_clk,
  input  logic       ulpi_rst,
  input  logic       ulpi_dir,
  input  logic       ulpi_nxt,
  input  logic [7:0] ulpi_data_in,
  output logic [7:0] ulpi_data_out,
  output logic       ulpi_stp,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [5:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       resp_valid,
  output logic [7:0] resp_rdata,
  output logic       resp_err,
  output logic       rx_cmd_valid,
  output logic [7:0] rx_cmd
);

  typedef enum logic [2:0] {
    IDLE, TXCMD, WDATA, STP, RD_TURN, RD_DATA, WAIT_DIR, TURN
  } state_t;

  localparam logic [3:0] LIMIT = 4'(RETRY_LIMIT);

  state_t     state, state_d;
  logic       dir_q;
  logic       pend, pend_d;
  logic       wr, wr_d;
  logic [5:0] addr, addr_d;
  logic [7:0] wdata, wdata_d;
  logic [3:0] aborts, aborts_d;
  logic       resp_valid_d, resp_err_d;
  logic [7:0] resp_rdata_d, data_out_d;
  logic       stp_d, ready_d, rx_valid_d;

  always_comb begin
    state_d      = state;
    pend_d       = pend;
    wr_d         = wr;
    addr_d       = addr;
    wdata_d      = wdata;
    aborts_d     = aborts;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 8'h00;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          state_d  = TXCMD;
          pend_d   = 1'b1;
          wr_d     = req_write;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          aborts_d = 4'd0;
        end
      end
      TXCMD: begin
        if (ulpi_dir) begin
          state_d  = WAIT_DIR;
          aborts_d = aborts + 4'd1;
        end else if (ulpi_nxt) begin
          state_d = wr ? WDATA : RD_TURN;
        end
      end
      WDATA: begin
        if (ulpi_dir) begin
          state_d  = WAIT_DIR;
          aborts_d = aborts + 4'd1;
        end else if (ulpi_nxt) begin
          state_d      = STP;
          resp_valid_d = 1'b1;
          pend_d       = 1'b0;
        end
      end
      STP: state_d = IDLE;
      RD_TURN: begin
        // The PHY must take the bus right after accepting a read command.
        if (!ulpi_dir) begin
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          pend_d       = 1'b0;
        end else if (ulpi_nxt) begin
          state_d  = WAIT_DIR;
          aborts_d = aborts + 4'd1;
        end else begin
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        state_d      = WAIT_DIR;
        resp_valid_d = 1'b1;
        resp_rdata_d = ulpi_data_in;
        pend_d       = 1'b0;
      end
      WAIT_DIR: if (!ulpi_dir) state_d = TURN;
      TURN: begin
        if (!pend) begin
          state_d = IDLE;
        end else if (aborts >= LIMIT) begin
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          pend_d       = 1'b0;
        end else begin
          state_d = TXCMD;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bus outputs are registered from the next state so they line up with it.
    case (state_d)
      TXCMD:   data_out_d = {1'b1, ~wr_d, addr_d};
      WDATA:   data_out_d = wdata_d;
      default: data_out_d = 8'h00;
    endcase
    stp_d      = (state_d == STP);
    ready_d    = (state_d == IDLE) && !ulpi_dir && !dir_q;
    rx_valid_d = ulpi_dir && dir_q && !ulpi_nxt && (state != RD_DATA);
  end

  always_ff @(posedge ulpi_clk or posedge ulpi_rst) begin
    if (ulpi_rst) begin
      state         <= IDLE;
      dir_q         <= 1'b0;
      pend          <= 1'b0;
      wr            <= 1'b0;
      addr          <= 6'd0;
      wdata         <= 8'h00;
      aborts        <= 4'd0;
      ulpi_data_out <= 8'h00;
      ulpi_stp      <= 1'b0;
      req_ready     <= 1'b0;
      resp_valid    <= 1'b0;
      resp_rdata    <= 8'h00;
      resp_err      <= 1'b0;
      rx_cmd_valid  <= 1'b0;
      rx_cmd        <= 8'h00;
    end else begin
      state         <= state_d;
      dir_q         <= ulpi_dir;
      pend          <= pend_d;
      wr            <= wr_d;
      addr          <= addr_d;
      wdata         <= wdata_d;
      aborts        <= aborts_d;
      ulpi_data_out <= data_out_d;
      ulpi_stp      <= stp_d;
      req_ready     <= ready_d;
      resp_valid    <= resp_valid_d;
      resp_rdata    <= resp_rdata_d;
      resp_err      <= resp_err_d;
      rx_cmd_valid  <= rx_valid_d;
      if (rx_valid_d) rx_cmd <= ulpi_data_in;
    end
  end

endmodule

// File: tb/tb_ulpi_reg_access.sv
// Self-checking bench for ulpi_reg_access: vector table for the main flows,
// hand sequences for retry exhaustion and asynchronous reset.
`timescale 1ns/1ps
module tb_ulpi_reg_access;

  logic       clk, rst;
  logic       dir, nxt;
  logic [7:0] din;
  logic       rv, rw;
  logic [5:0] ra;
  logic [7:0] rwd;

  logic [7:0] data_out, data_out_b;
  logic       stp, stp_b, ready, ready_b;
  logic       resp_valid, resp_valid_b, resp_err, resp_err_b;
  logic [7:0] resp_rdata, resp_rdata_b;
  logic       rx_valid, rx_valid_b;
  logic [7:0] rx_cmd, rx_cmd_b;

  int checks = 0;
  int errors = 0;

  ulpi_reg_access dut (
    .ulpi_clk(clk), .ulpi_rst(rst), .ulpi_dir(dir), .ulpi_nxt(nxt),
    .ulpi_data_in(din), .ulpi_data_out(data_out), .ulpi_stp(stp),
    .req_valid(rv), .req_ready(ready), .req_write(rw), .req_addr(ra),
    .req_wdata(rwd), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .rx_cmd_valid(rx_valid), .rx_cmd(rx_cmd)
  );

  ulpi_reg_access #(.RETRY_LIMIT(2)) dut2 (
    .ulpi_clk(clk), .ulpi_rst(rst), .ulpi_dir(dir), .ulpi_nxt(nxt),
    .ulpi_data_in(din), .ulpi_data_out(data_out_b), .ulpi_stp(stp_b),
    .req_valid(rv), .req_ready(ready_b), .req_write(rw), .req_addr(ra),
    .req_wdata(rwd), .resp_valid(resp_valid_b), .resp_rdata(resp_rdata_b),
    .resp_err(resp_err_b), .rx_cmd_valid(rx_valid_b), .rx_cmd(rx_cmd_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       dir, nxt;
    logic [7:0] din;
    logic       rv, rw;
    logic [5:0] ra;
    logic [7:0] rwd;
    logic [7:0] e_data;
    logic       e_stp, e_ready, e_rv, e_err;
    logic [7:0] e_rdata;
    logic       e_rxv;
    logic [7:0] e_rx;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic d, input logic n, input logic [7:0] di,
                     input logic v, input logic w, input logic [5:0] a,
                     input logic [7:0] wd, input logic [7:0] ed,
                     input logic es, input logic er, input logic ev,
                     input logic ee, input logic [7:0] erd,
                     input logic ex, input logic [7:0] erx);
    vec_t t;
    t.dir = d; t.nxt = n; t.din = di; t.rv = v; t.rw = w; t.ra = a; t.rwd = wd;
    t.e_data = ed; t.e_stp = es; t.e_ready = er; t.e_rv = ev; t.e_err = ee;
    t.e_rdata = erd; t.e_rxv = ex; t.e_rx = erx;
    vecs.push_back(t);
  endtask

  task automatic check_val(input string name, input logic [7:0] act,
                           input logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", name, act, exp_v);
    end
  endtask

  // One clock: drive inputs, take the edge, settle just after it.
  task automatic apply_stimulus(input logic d, input logic n, input logic [7:0] di,
                                input logic v, input logic w,
                                input logic [5:0] a, input logic [7:0] wd);
    dir = d; nxt = n; din = di; rv = v; rw = w; ra = a; rwd = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input int idx, input vec_t t);
    check_val($sformatf("vec%0d.data", idx), data_out, t.e_data);
    check_val($sformatf("vec%0d.stp", idx), 8'(stp), 8'(t.e_stp));
    check_val($sformatf("vec%0d.ready", idx), 8'(ready), 8'(t.e_ready));
    check_val($sformatf("vec%0d.resp_valid", idx), 8'(resp_valid), 8'(t.e_rv));
    check_val($sformatf("vec%0d.rx_valid", idx), 8'(rx_valid), 8'(t.e_rxv));
    if (t.e_rv) begin
      check_val($sformatf("vec%0d.resp_err", idx), 8'(resp_err), 8'(t.e_err));
      check_val($sformatf("vec%0d.resp_rdata", idx), resp_rdata, t.e_rdata);
    end
    if (t.e_rxv) check_val($sformatf("vec%0d.rx_cmd", idx), rx_cmd, t.e_rx);
  endtask

  initial begin
    //  dir nxt din    rv rw addr   wdata  | data  stp rdy rv err rdata rxv rx
    add(0, 0, 8'h00, 0, 0, 6'h00, 8'h00,   8'h00, 0, 1, 0, 0, 8'h00, 0, 8'h00);
    // register write 0A <= 55
    add(0, 0, 8'h00, 1, 1, 6'h0A, 8'h55,   8'h8A, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    add(0, 0, 8'h00, 0, 0, 6'h00, 8'h00,   8'h8A, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    add(0, 1, 8'h00, 0, 0, 6'h00, 8'h00,   8'h55, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    add(0, 1, 8'h00, 0, 0, 6'h00, 8'h00,   8'h00, 1, 0, 1, 0, 8'h00, 0, 8'h00);
    add(0, 0, 8'h00, 0, 0, 6'h00, 8'h00,   8'h00, 0, 1, 0, 0, 8'h00, 0, 8'h00);
    // register read 00 -> 24
    add(0, 0, 8'h00, 1, 0, 6'h00, 8'h00,   8'hC0, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    add(0, 1, 8'h00, 0, 0, 6'h00, 8'h00,   8'h00, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    add(1, 0, 8'h00, 0, 0, 6'h00, 8'h00,   8'h00, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    add(1, 0, 8'h24, 0, 0, 6'h00, 8'h00,   8'h00, 0, 0, 1, 0, 8'h24, 0, 8'h00);
    add(0, 0, 8'h00, 0, 0, 6'h00, 8'h00,   8'h00, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    add(0, 0, 8'h00, 0, 0, 6'h00, 8'h00,   8'h00, 0, 1, 0, 0, 8'h00, 0, 8'h00);
    // write aborted in TXCMD by RX CMD 4D, then retried
    add(0, 0, 8'h00, 1, 1, 6'h0A, 8'h55,   8'h8A, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    add(1, 0, 8'h00, 0, 0, 6'h00, 8'h00,   8'h00, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    add(1, 0, 8'h4D, 0, 0, 6'h00, 8'h00,   8'h00, 0, 0, 0, 0, 8'h00, 1, 8'h4D);
    add(0, 0, 8'h00, 0, 0, 6'h00, 8'h00,   8'h00, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    add(0, 0, 8'h00, 0, 0, 6'h00, 8'h00,   8'h8A, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    add(0, 1, 8'h00, 0, 0, 6'h00, 8'h00,   8'h55, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    add(0, 1, 8'h00, 0, 0, 6'h00, 8'h00,   8'h00, 1, 0, 1, 0, 8'h00, 0, 8'h00);
    add(0, 0, 8'h00, 0, 0, 6'h00, 8'h00,   8'h00, 0, 1, 0, 0, 8'h00, 0, 8'h00);
    // idle RX traffic: turnaround and packet bytes are not RX CMDs
    add(1, 0, 8'h11, 0, 0, 6'h00, 8'h00,   8'h00, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    add(1, 1, 8'hAA, 0, 0, 6'h00, 8'h00,   8'h00, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    add(1, 0, 8'h4E, 0, 0, 6'h00, 8'h00,   8'h00, 0, 0, 0, 0, 8'h00, 1, 8'h4E);
    add(0, 0, 8'h00, 0, 0, 6'h00, 8'h00,   8'h00, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    add(0, 0, 8'h00, 0, 0, 6'h00, 8'h00,   8'h00, 0, 1, 0, 0, 8'h00, 0, 8'h00);
    // read where the PHY never takes the bus
    add(0, 0, 8'h00, 1, 0, 6'h3F, 8'h00,   8'hFF, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    add(0, 1, 8'h00, 0, 0, 6'h00, 8'h00,   8'h00, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    add(0, 0, 8'h77, 0, 0, 6'h00, 8'h00,   8'h00, 0, 1, 1, 1, 8'h00, 0, 8'h00);
    // read aborted in RD_TURN (dir & nxt), then retried to completion
    add(0, 0, 8'h00, 1, 0, 6'h01, 8'h00,   8'hC1, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    add(0, 1, 8'h00, 0, 0, 6'h00, 8'h00,   8'h00, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    add(1, 1, 8'hAB, 0, 0, 6'h00, 8'h00,   8'h00, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    add(0, 0, 8'h00, 0, 0, 6'h00, 8'h00,   8'h00, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    add(0, 0, 8'h00, 0, 0, 6'h00, 8'h00,   8'hC1, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    add(0, 1, 8'h00, 0, 0, 6'h00, 8'h00,   8'h00, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    add(1, 0, 8'h00, 0, 0, 6'h00, 8'h00,   8'h00, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    add(1, 0, 8'h5A, 0, 0, 6'h00, 8'h00,   8'h00, 0, 0, 1, 0, 8'h5A, 0, 8'h00);
    add(0, 0, 8'h00, 0, 0, 6'h00, 8'h00,   8'h00, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    add(0, 0, 8'h00, 0, 0, 6'h00, 8'h00,   8'h00, 0, 1, 0, 0, 8'h00, 0, 8'h00);

    rst = 1'b1; dir = 0; nxt = 0; din = 0; rv = 0; rw = 0; ra = 0; rwd = 0;
    @(posedge clk); #1;
    check_val("reset.data", data_out, 8'h00);
    check_val("reset.ready", 8'(ready), 8'h00);
    check_val("reset.resp_valid", 8'(resp_valid), 8'h00);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].dir, vecs[i].nxt, vecs[i].din, vecs[i].rv,
                     vecs[i].rw, vecs[i].ra, vecs[i].rwd);
      check_output(i, vecs[i]);
    end

    // Every attempt aborted: limit-2 instance gives up, default instance retries.
    apply_stimulus(0, 0, 8'h00, 1, 1, 6'h0A, 8'h55);
    check_val("retry.tx1", data_out_b, 8'h8A);
    apply_stimulus(1, 0, 8'h00, 0, 0, 6'h00, 8'h00);
    apply_stimulus(0, 0, 8'h00, 0, 0, 6'h00, 8'h00);
    check_val("retry.turn1", data_out_b, 8'h00);
    apply_stimulus(0, 0, 8'h00, 0, 0, 6'h00, 8'h00);
    check_val("retry.tx2", data_out_b, 8'h8A);
    apply_stimulus(1, 0, 8'h00, 0, 0, 6'h00, 8'h00);
    check_val("retry.abort2_rv", 8'(resp_valid_b), 8'h00);
    apply_stimulus(0, 0, 8'h00, 0, 0, 6'h00, 8'h00);
    apply_stimulus(0, 0, 8'h00, 0, 0, 6'h00, 8'h00);
    check_val("retry.err_rv", 8'(resp_valid_b), 8'h01);
    check_val("retry.err_flag", 8'(resp_err_b), 8'h01);
    check_val("retry.no_tx3", data_out_b, 8'h00);
    check_val("retry.default_tx3", data_out, 8'h8A);
    check_val("retry.default_rv", 8'(resp_valid), 8'h00);
    apply_stimulus(0, 1, 8'h00, 0, 0, 6'h00, 8'h00);
    check_val("retry.after_rv", 8'(resp_valid_b), 8'h00);
    check_val("retry.default_wdata", data_out, 8'h55);
    apply_stimulus(0, 1, 8'h00, 0, 0, 6'h00, 8'h00);
    check_val("retry.default_done", 8'(resp_valid), 8'h01);
    check_val("retry.default_stp", 8'(stp), 8'h01);
    check_val("retry.limit_quiet", 8'(resp_valid_b), 8'h00);
    apply_stimulus(0, 0, 8'h00, 0, 0, 6'h00, 8'h00);

    // Asynchronous reset in the middle of a write data phase.
    apply_stimulus(0, 0, 8'h00, 1, 1, 6'h0A, 8'h55);
    apply_stimulus(0, 1, 8'h00, 0, 0, 6'h00, 8'h00);
    check_val("rst.wdata", data_out, 8'h55);
    #2 rst = 1'b1;
    #1;
    check_val("rst.async_data", data_out, 8'h00);
    check_val("rst.async_stp", 8'(stp), 8'h00);
    check_val("rst.async_ready", 8'(ready), 8'h00);
    apply_stimulus(0, 1, 8'h00, 0, 0, 6'h00, 8'h00);
    check_val("rst.held_data", data_out, 8'h00);
    rst = 1'b0;
    apply_stimulus(0, 1, 8'h00, 0, 0, 6'h00, 8'h00);
    check_val("rst.no_resp", 8'(resp_valid), 8'h00);
    check_val("rst.no_stp", 8'(stp), 8'h00);
    check_val("rst.ready_back", 8'(ready), 8'h01);
    apply_stimulus(0, 0, 8'h00, 0, 0, 6'h00, 8'h00);
    check_val("rst.still_no_resp", 8'(resp_valid), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
